// File: rtl/microwave_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : microwave_pkg                                                |
// | Purpose   : Shared types for the microwave cooking timer: FSM states,    |
// |             BCD digit and packed mm:ss display word.                     |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
package microwave_pkg;

   typedef enum logic [1:0] {
      ENTRY = 2'd0,
      RUN   = 2'd1,
      HOLD  = 2'd2,
      DONE  = 2'd3
   } timer_state_t;

   typedef logic [3:0] bcd_t;

   typedef struct packed {
      bcd_t m10;
      bcd_t m1;
      bcd_t s10;
      bcd_t s1;
   } mmss_t;

   localparam mmss_t MMSS_ZERO = '0;

   // Digits above 9 on the keypad bus are treated as "no key".
   function automatic logic is_key_digit(input bcd_t d);
      return (d <= 4'd9);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_mmss_dec.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : bcd_mmss_dec                                                 |
// | Purpose   : Combinational one-second decrement of a BCD mm:ss word.      |
// |             Seconds digits above 59 are counted down as entered; only a  |
// |             borrow out of the seconds field reloads it to 59.            |
// | Ports     : time_i    [15:0] current {m10,m1,s10,s1}                     |
// |             time_o    [15:0] value one second later (0000 stays 0000)    |
// |             is_zero_o        time_o equals 00:00                         |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module bcd_mmss_dec
   import microwave_pkg::*;
(
   input  logic [15:0] time_i,
   output logic [15:0] time_o,
   output logic        is_zero_o
);

   mmss_t cur_w;
   mmss_t nxt_w;

   always_comb begin
      cur_w = mmss_t'(time_i);
      nxt_w = cur_w;
      if (cur_w.s1 != 4'd0) begin
         nxt_w.s1 = cur_w.s1 - 4'd1;
      end else if (cur_w.s10 != 4'd0) begin
         nxt_w.s10 = cur_w.s10 - 4'd1;
         nxt_w.s1  = 4'd9;
      end else if (cur_w.m1 != 4'd0) begin
         nxt_w.m1  = cur_w.m1 - 4'd1;
         nxt_w.s10 = 4'd5;
         nxt_w.s1  = 4'd9;
      end else if (cur_w.m10 != 4'd0) begin
         nxt_w.m10 = cur_w.m10 - 4'd1;
         nxt_w.m1  = 4'd9;
         nxt_w.s10 = 4'd5;
         nxt_w.s1  = 4'd9;
      end
   end

   assign time_o    = nxt_w;
   assign is_zero_o = (nxt_w == MMSS_ZERO);

endmodule
`default_nettype wire

// File: rtl/cook_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : cook_timer                                                   |
// | Purpose   : Minutes:seconds cooking timer. Keypad digits shift into the  |
// |             display, the time counts down one second per TICK_DIV clocks |
// |             while heat is asserted, and finish is raised at 00:00.       |
// | Ports     : clk        clock, rising edge                                |
// |             nrst       asynchronous active-low reset                     |
// |             key_valid  one-cycle strobe qualifying key_digit             |
// |             key_digit  BCD digit 0..9 (10..15 ignored)                   |
// |             clear      cancel: zero time, drop finish                    |
// |             heat       controller is cooking (count enable)              |
// |             finish     time expired (level, held until clear/key)        |
// |             has_time   display is not 00:00                              |
// |             disp       BCD {m10,m1,s10,s1}                               |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module cook_timer
   import microwave_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        key_valid,
   input  logic [3:0]  key_digit,
   input  logic        clear,
   input  logic        heat,
   output logic        finish,
   output logic        has_time,
   output logic [15:0] disp
);

   localparam int            PW     = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PS_ONE = PW'(1);

   timer_state_t  state_q, state_d;
   mmss_t         disp_q,  disp_d;
   logic [PW-1:0] presc_q, presc_d;

   logic [15:0]   dec_time_w;
   logic          dec_zero_w;
   logic          key_ok_w;

   bcd_mmss_dec u_dec (
      .time_i    (disp_q),
      .time_o    (dec_time_w),
      .is_zero_o (dec_zero_w)
   );

   assign key_ok_w = key_valid && is_key_digit(key_digit);

   always_comb begin
      state_d = state_q;
      disp_d  = disp_q;
      presc_d = presc_q;

      if (clear) begin
         state_d = ENTRY;
         disp_d  = MMSS_ZERO;
         presc_d = '0;
      end else begin
         case (state_q)
            ENTRY: begin
               // The edge that sees heat already counts as the first
               // heated cycle of the first second.
               if (heat) begin
                  if (disp_q == MMSS_ZERO) begin
                     state_d = DONE;
                  end else begin
                     state_d = RUN;
                     presc_d = presc_q + PS_ONE;
                  end
               end else if (key_ok_w) begin
                  disp_d = mmss_t'({disp_q.m1, disp_q.s10, disp_q.s1, key_digit});
               end
            end
            RUN: begin
               // A pending tick is applied even if heat drops on this edge;
               // the HOLD transition happens after the decrement.
               if (presc_q == PS_MAX) begin
                  presc_d = '0;
                  disp_d  = mmss_t'(dec_time_w);
                  if (dec_zero_w) begin
                     state_d = DONE;
                  end else if (!heat) begin
                     state_d = HOLD;
                  end
               end else if (heat) begin
                  presc_d = presc_q + PS_ONE;
               end else begin
                  state_d = HOLD;
               end
            end
            HOLD: begin
               // HOLD is only entered with the prescaler below its wrap
               // value, so resuming can always advance it by one.
               if (heat) begin
                  state_d = RUN;
                  presc_d = presc_q + PS_ONE;
               end
            end
            DONE: begin
               disp_d = MMSS_ZERO;
               if (key_ok_w) begin
                  state_d = ENTRY;
                  disp_d  = mmss_t'({12'h000, key_digit});
               end
            end
            default: begin
               state_d = ENTRY;
               disp_d  = MMSS_ZERO;
               presc_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= ENTRY;
         disp_q  <= MMSS_ZERO;
         presc_q <= '0;
      end else begin
         state_q <= state_d;
         disp_q  <= disp_d;
         presc_q <= presc_d;
      end
   end

   assign finish   = (state_q == DONE);
   assign has_time = (disp_q != MMSS_ZERO);
   assign disp     = disp_q;

endmodule
`default_nettype wire

// File: tb/tb_cook_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_cook_timer                                                |
// | Purpose   : Self-checking bench for cook_timer (TICK_DIV = 4): directed  |
// |             scenarios plus random stimulus against a decimal-arithmetic  |
// |             reference model of the timer.                                |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
module tb_cook_timer;

   localparam int TD = 4;

   localparam int MD_ENTRY = 0;
   localparam int MD_COUNT = 1;
   localparam int MD_PAUSE = 2;
   localparam int MD_DONE  = 3;

   logic        clk = 1'b0;
   logic        nrst;
   logic        key_valid;
   logic [3:0]  key_digit;
   logic        clear;
   logic        heat;
   logic        finish;
   logic        has_time;
   logic [15:0] disp;

   int errors = 0;
   int checks = 0;

   cook_timer #(.TICK_DIV(TD)) dut (
      .clk       (clk),
      .nrst      (nrst),
      .key_valid (key_valid),
      .key_digit (key_digit),
      .clear     (clear),
      .heat      (heat),
      .finish    (finish),
      .has_time  (has_time),
      .disp      (disp)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] d);
      key_valid = 1'b1;
      key_digit = d;
      step();
      key_valid = 1'b0;
   endtask

   // Decimal view of the display: 0..9999, minutes*100 + seconds.
   function automatic logic [15:0] to_bcd(input int n);
      return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   function automatic int one_second_less(input int n);
      int mm, ss;
      mm = n / 100;
      ss = n % 100;
      if (ss > 0) ss = ss - 1;
      else if (mm > 0) begin
         mm = mm - 1;
         ss = 59;
      end
      return mm * 100 + ss;
   endfunction

   task automatic test_reset();
      nrst = 1'b0; key_valid = 1'b0; key_digit = 4'd0; clear = 1'b0; heat = 1'b0;
      step(); step();
      checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL reset_disp got=%h exp=0000", disp); end
      checks++; if (finish !== 1'b0) begin errors++; $display("FAIL reset_finish got=%b exp=0", finish); end
      checks++; if (has_time !== 1'b0) begin errors++; $display("FAIL reset_has_time got=%b exp=0", has_time); end
      nrst = 1'b1;
      step();
   endtask

   task automatic test_entry();
      press(4'd1);
      press(4'd3);
      checks++; if (disp !== 16'h0013) begin errors++; $display("FAIL entry_disp got=%h exp=0013", disp); end
      checks++; if (has_time !== 1'b1) begin errors++; $display("FAIL entry_has_time got=%b exp=1", has_time); end
      press(4'd12);
      checks++; if (disp !== 16'h0013) begin errors++; $display("FAIL entry_bad_key got=%h exp=0013", disp); end
      press(4'd4); press(4'd5); press(4'd6);
      checks++; if (disp !== 16'h3456) begin errors++; $display("FAIL entry_shift_out got=%h exp=3456", disp); end
      clear = 1'b1; step(); clear = 1'b0;
      checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL entry_clear got=%h exp=0000", disp); end
   endtask

   task automatic test_countdown();
      press(4'd2);
      heat = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         if (i == 3) begin
            checks++; if (disp !== 16'h0002) begin errors++; $display("FAIL cd_before_tick got=%h exp=0002", disp); end
         end
         if (i == 4) begin
            checks++; if (disp !== 16'h0001) begin errors++; $display("FAIL cd_first_tick got=%h exp=0001", disp); end
         end
         if (i == 7) begin
            checks++; if (finish !== 1'b0) begin errors++; $display("FAIL cd_early_finish got=%b exp=0", finish); end
         end
      end
      checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL cd_expiry_disp got=%h exp=0000", disp); end
      checks++; if (finish !== 1'b1) begin errors++; $display("FAIL cd_expiry_finish got=%b exp=1", finish); end
      heat = 1'b0;
      step(); step(); step();
      checks++; if (finish !== 1'b1) begin errors++; $display("FAIL cd_finish_held got=%b exp=1", finish); end
      press(4'd5);
      checks++; if (finish !== 1'b0) begin errors++; $display("FAIL cd_key_finish got=%b exp=0", finish); end
      checks++; if (disp !== 16'h0005) begin errors++; $display("FAIL cd_key_disp got=%h exp=0005", disp); end
      clear = 1'b1; step(); clear = 1'b0;
   endtask

   task automatic test_zero_start();
      heat = 1'b1;
      step();
      checks++; if (finish !== 1'b1) begin errors++; $display("FAIL zero_start_finish got=%b exp=1", finish); end
      step();
      heat = 1'b0;
      clear = 1'b1; step(); clear = 1'b0;
      checks++; if (finish !== 1'b0) begin errors++; $display("FAIL zero_start_clear got=%b exp=0", finish); end
   endtask

   task automatic test_borrow();
      press(4'd1); press(4'd0); press(4'd0);
      heat = 1'b1;
      step(); step(); step(); step();
      checks++; if (disp !== 16'h0059) begin errors++; $display("FAIL borrow_disp got=%h exp=0059", disp); end
      heat = 1'b0;
      step();
      clear = 1'b1; step(); clear = 1'b0;
      press(4'd1); press(4'd7); press(4'd5);
      heat = 1'b1;
      step(); step(); step(); step();
      checks++; if (disp !== 16'h0174) begin errors++; $display("FAIL big_seconds_disp got=%h exp=0174", disp); end
      heat = 1'b0;
      step();
      clear = 1'b1; step(); clear = 1'b0;
   endtask

   task automatic test_hold();
      press(4'd3);
      heat = 1'b1;
      step(); step();
      heat = 1'b0;
      for (int i = 0; i < 10; i++) begin
         key_valid = (i % 3 == 1);
         key_digit = 4'd7;
         step();
      end
      key_valid = 1'b0;
      checks++; if (disp !== 16'h0003) begin errors++; $display("FAIL hold_disp got=%h exp=0003", disp); end
      heat = 1'b1;
      step();
      checks++; if (disp !== 16'h0003) begin errors++; $display("FAIL hold_resume1 got=%h exp=0003", disp); end
      step();
      checks++; if (disp !== 16'h0002) begin errors++; $display("FAIL hold_resume2 got=%h exp=0002", disp); end
      heat = 1'b0;
      step();
      clear = 1'b1; step(); clear = 1'b0;
   endtask

   task automatic test_clear_on_tick();
      logic seen;
      seen = 1'b0;
      press(4'd1);
      heat = 1'b1;
      step(); step(); step();
      seen = seen | finish;
      clear = 1'b1;
      step();
      seen = seen | finish;
      clear = 1'b0;
      heat  = 1'b0;
      checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL clr_tick_disp got=%h exp=0000", disp); end
      step(); step();
      seen = seen | finish;
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL clr_tick_finish got=%b exp=0", seen); end
   endtask

   task automatic test_async_reset();
      press(4'd5); press(4'd0);
      heat = 1'b1;
      step(); step();
      #2;
      nrst = 1'b0;
      #1;
      checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL arst_disp got=%h exp=0000", disp); end
      checks++; if (has_time !== 1'b0) begin errors++; $display("FAIL arst_has_time got=%b exp=0", has_time); end
      checks++; if (finish !== 1'b0) begin errors++; $display("FAIL arst_finish got=%b exp=0", finish); end
      heat = 1'b0;
      step();
      nrst = 1'b1;
      step();
      checks++; if (disp !== 16'h0000) begin errors++; $display("FAIL arst_after got=%h exp=0000", disp); end
   endtask

   task automatic test_random();
      int          n, ph, mode;
      logic        kv, cl, ht;
      logic [3:0]  dg;
      clear = 1'b1; key_valid = 1'b0; heat = 1'b0;
      step();
      clear = 1'b0;
      n = 0; ph = 0; mode = MD_ENTRY; ht = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         kv = ($urandom_range(0, 99) < 12);
         dg = 4'($urandom_range(0, 15));
         cl = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 99) < 6) ht = ~ht;
         key_valid = kv; key_digit = dg; clear = cl; heat = ht;
         step();
         // Reference: ph counts heated cycles toward the next second.
         if (cl) begin
            mode = MD_ENTRY; n = 0; ph = 0;
         end else if (mode == MD_ENTRY) begin
            if (ht) begin
               if (n == 0) mode = MD_DONE;
               else begin mode = MD_COUNT; ph = ph + 1; end
            end else if (kv && dg <= 4'd9) begin
               n = (n * 10 + int'(dg)) % 10000;
            end
         end else if (mode == MD_COUNT) begin
            if (ph == TD - 1) begin
               ph = 0;
               n  = one_second_less(n);
               if (n == 0) mode = MD_DONE;
               else if (!ht) mode = MD_PAUSE;
            end else if (ht) ph = ph + 1;
            else mode = MD_PAUSE;
         end else if (mode == MD_PAUSE) begin
            if (ht) begin mode = MD_COUNT; ph = ph + 1; end
         end else begin
            if (kv && dg <= 4'd9) begin mode = MD_ENTRY; n = int'(dg); end
         end
         checks++; if (disp !== to_bcd(n)) begin errors++; $display("FAIL rand_disp cyc=%0d got=%h exp=%h", i, disp, to_bcd(n)); end
         checks++; if (finish !== (mode == MD_DONE)) begin errors++; $display("FAIL rand_finish cyc=%0d got=%b exp=%b", i, finish, (mode == MD_DONE)); end
         checks++; if (has_time !== (n != 0)) begin errors++; $display("FAIL rand_has_time cyc=%0d got=%b exp=%b", i, has_time, (n != 0)); end
      end
      key_valid = 1'b0; clear = 1'b0; heat = 1'b0;
   endtask

   initial begin
      test_reset();
      test_entry();
      test_countdown();
      test_zero_start();
      test_borrow();
      test_hold();
      test_clear_on_tick();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout reached got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
